input_irq_ctrl: RTL and testbench
=================================

INPUT_IRQ_CTRL -- requirements
Module: input_irq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, sets the consecutive stable cycles needed to accept a button change; legal range 2..255.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1; 1 means a button reads 0 when pressed.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_io_sw  in  32  raw switch inputs, asynchronous to i_clk.
REQ-006 i_io_btn  in  4  raw push-button inputs, asynchronous to i_clk.
REQ-007 i_lsu_addr  in  4  byte offset; bits [3:2] select the register, bits [1:0] are ignored.
REQ-008 i_lsu_wren  in  1  write strobe, one cycle per write.
REQ-009 i_lsu_rden  in  1  read strobe, one cycle per read.
REQ-010 i_lsu_wdata  in  32  write data.
REQ-011 o_lsu_rdata  out  32  read data.
REQ-012 o_irq  out  1  interrupt request to the CPU interrupt unit.
REQ-013 i_irq_ack  in  1  one-cycle pulse from the CPU when it takes the trap.

Function
REQ-014 Register map:
- 0x0 SW: synchronized switch value, read-only.
- 0x4 BTN: debounced pressed mask [3:0], 1 means pressed; read-only.
- 0x8 PENDING: [3:0] button-press events, [4] switch-change event; write-1-to-clear.
- 0xC ENABLE: [4:0] mask, read/write.
- Unused bits read 0.
REQ-015 Every raw input passes through a 2-flop synchronizer; no other logic samples a raw input.
REQ-016 Switch change event: the synchronized value differs from its value one cycle earlier.
- A change sampled at edge k is visible in SW and sets PENDING[4] at edge k+2.
REQ-017 Each button has an 8-bit debounce counter.
- The counter clears whenever the synchronized level equals the debounced level.
- Otherwise it increments.
- When the counter is DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronized level and the counter clears at that edge.
REQ-018 Press event: debounced button goes from released to pressed; it sets PENDING[i] on the same edge the debounced level changes. A release sets no event.
- With D=4, a clean press sampled at edge k sets PENDING[i] at edge k+5.
REQ-019 Write to 0x8 clears the PENDING bits where wdata is 1. If a set event and a clear hit the same bit in the same cycle, the set wins.
REQ-020 Pending bits latch regardless of ENABLE; ENABLE gates only interrupt generation.
REQ-021 Reads are registered: o_lsu_rdata is valid on the cycle after i_lsu_rden and holds until the next read. Writes to read-only or unmapped offsets are ignored.
REQ-022 Interrupt FSM has three states: IDLE, REQ, SERVICE.
- IDLE -> REQ when (PENDING & ENABLE) != 0.
- REQ -> SERVICE on i_irq_ack.
- SERVICE -> IDLE on any write to offset 0x8 (end of interrupt).
- Any other condition holds the current state.
REQ-023 o_irq = 1 only in REQ and is driven from a register.
- A switch change sampled at edge k, with ENABLE[4]=1 and the FSM in IDLE, raises o_irq at edge k+3.
REQ-024 In SERVICE, new events still latch but o_irq stays 0.
- After SERVICE -> IDLE, the FSM re-enters REQ on the next edge if enabled bits are still pending.
REQ-025 i_irq_ack outside REQ is ignored.
- Clearing ENABLE while in REQ does not drop o_irq; only i_irq_ack or reset leaves REQ.

Reset
REQ-026 Reset values:
- Synchronizers, SW and the previous-switch register: 0.
- Debounced buttons: released, BTN=0. Counters: 0.
- PENDING=0, ENABLE=0, FSM=IDLE, o_irq=0, o_lsu_rdata=0.
REQ-027 Asserting i_rst_n low mid-operation forces o_irq to 0 immediately (asynchronously) and discards pending events and in-flight debounce counts.
REQ-028 If i_io_sw is nonzero when reset is released, a switch-change event fires and PENDING[4] sets 2 edges after release.

Verification
REQ-029 Reset release with i_io_sw=100 -> SW reads 100 and PENDING reads 0x10.
- With ENABLE=0x10 written, o_irq rises one edge after both PENDING[4] and ENABLE[4] are set.
REQ-030 Button 0 (active-low) held at 0 for 10 cycles, D=4 -> PENDING[0] sets at edge k+5 and BTN reads 0x1.
- A 3-cycle glitch to 0 -> no event and BTN stays 0.
REQ-031 o_irq=1, pulse i_irq_ack -> o_irq=0 next edge.
- A switch change during SERVICE sets PENDING[4] with o_irq still 0.
- Write 0x10 to 0x8 -> IDLE, then o_irq stays 0.
REQ-032 Write 0x1 to 0x8 on the same edge a new button-0 press sets PENDING[0] -> PENDING[0] reads 1.
REQ-033 Write 0x08 to 0x8 while PENDING[0] is set -> after EOI the FSM re-enters REQ and o_irq=1 one edge later.
REQ-034 i_rst_n low in REQ -> o_irq=0 before the next clock edge; all registers read their REQ-026 values.

Source files
------------

// File: rtl/input_irq_ctrl_if.sv
// Load/store bus into the input/interrupt controller: byte-offset select,
// single-cycle read/write strobes and registered read data.
interface input_irq_ctrl_if;
  logic [3:0]  i_lsu_addr;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [31:0] i_lsu_wdata;
  logic [31:0] o_lsu_rdata;

  modport master (
    output i_lsu_addr,
    output i_lsu_wren,
    output i_lsu_rden,
    output i_lsu_wdata,
    input  o_lsu_rdata
  );

  modport slave (
    input  i_lsu_addr,
    input  i_lsu_wren,
    input  i_lsu_rden,
    input  i_lsu_wdata,
    output o_lsu_rdata
  );
endinterface

// File: rtl/input_irq_ctrl.sv
// Switch/button input block: synchronizes and debounces raw inputs, latches
// change/press events and raises a level interrupt through an IDLE/REQ/SERVICE FSM.
module input_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_io_sw,
  input  logic [3:0]          i_io_btn,
  input_irq_ctrl_if.slave     lsu,
  output logic                o_irq,
  input  logic                i_irq_ack
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  logic [31:0]      sw_meta_q, sw_sync_q, sw_q;
  logic [3:0]       btn_meta_q, btn_sync_q;
  logic [3:0]       btn_lvl;
  logic [3:0]       btn_deb_q, btn_deb_d;
  logic [3:0][7:0]  btn_cnt_q, btn_cnt_d;
  logic [3:0]       press_evt;
  logic             sw_evt;
  logic [4:0]       pend_q, pend_d;
  logic [4:0]       en_q;
  logic [1:0]       reg_sel;
  logic             wr_pend, wr_en;
  logic [31:0]      rd_val, rdata_q;
  state_e           state_q;
  logic             irq_q;

  // Address bits [1:0] and write data above the 5 implemented bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{lsu.i_lsu_addr[1:0], lsu.i_lsu_wdata[31:5]};

  assign reg_sel = lsu.i_lsu_addr[3:2];
  assign wr_pend = lsu.i_lsu_wren && (reg_sel == 2'd2);
  assign wr_en   = lsu.i_lsu_wren && (reg_sel == 2'd3);

  // Buttons are tracked internally in "pressed" polarity.
  assign btn_lvl = btn_sync_q ^ {4{BTN_ACTIVE_LOW}};

  // sw_q doubles as the SW register and the one-cycle-old synchronized value.
  assign sw_evt = (sw_sync_q != sw_q);

  always_comb begin
    btn_cnt_d = btn_cnt_q;
    btn_deb_d = btn_deb_q;
    for (int i = 0; i < 4; i++) begin
      if (btn_lvl[i] == btn_deb_q[i]) begin
        btn_cnt_d[i] = '0;
      end else if (btn_cnt_q[i] == CntLast) begin
        btn_deb_d[i] = btn_lvl[i];
        btn_cnt_d[i] = '0;
      end else begin
        btn_cnt_d[i] = btn_cnt_q[i] + 8'd1;
      end
    end
  end

  assign press_evt = btn_deb_d & ~btn_deb_q;

  // Set wins over a same-cycle write-1-to-clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) begin
      pend_d = pend_d & ~lsu.i_lsu_wdata[4:0];
    end
    pend_d = pend_d | {sw_evt, press_evt};
  end

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      2'd0: rd_val = sw_q;
      2'd1: rd_val = {28'h0, btn_deb_q};
      2'd2: rd_val = {27'h0, pend_q};
      2'd3: rd_val = {27'h0, en_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_q       <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_deb_q  <= '0;
      btn_cnt_q  <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      rdata_q    <= '0;
    end else begin
      sw_meta_q  <= i_io_sw;
      sw_sync_q  <= sw_meta_q;
      sw_q       <= sw_sync_q;
      btn_meta_q <= i_io_btn;
      btn_sync_q <= btn_meta_q;
      btn_deb_q  <= btn_deb_d;
      btn_cnt_q  <= btn_cnt_d;
      pend_q     <= pend_d;
      if (wr_en) begin
        en_q <= lsu.i_lsu_wdata[4:0];
      end
      if (lsu.i_lsu_rden) begin
        rdata_q <= rd_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|(pend_q & en_q)) begin
            state_q <= StReq;
            irq_q   <= 1'b1;
          end
        end
        StReq: begin
          if (i_irq_ack) begin
            state_q <= StService;
            irq_q   <= 1'b0;
          end
        end
        StService: begin
          if (wr_pend) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq           = irq_q;
  assign lsu.o_lsu_rdata = rdata_q;

endmodule

// File: tb/tb_input_irq_ctrl.sv
// Self-checking bench for input_irq_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a history-based behavioural model.
module tb_input_irq_ctrl;

  localparam int unsigned D  = 4;
  localparam bit          AL = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic        ack;
  logic        irq;

  input_irq_ctrl_if bus ();

  input_irq_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (AL)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_io_sw  (sw),
    .i_io_btn (btn),
    .lsu      (bus),
    .o_irq    (irq),
    .i_irq_ack(ack)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw sample history; a synchronized value is the raw
  // sample from two edges earlier, a button level is accepted once it has
  // differed from the debounced level for D consecutive edges.
  logic [31:0] m_sw;
  logic [3:0]  m_deb;
  logic [4:0]  m_pend;
  logic [4:0]  m_en;
  int          m_state;  // 0 idle, 1 request, 2 service
  logic [31:0] m_rdata;
  logic [31:0] h_sw[$];
  logic [3:0]  h_btn[$];
  logic [3:0]  u_btn[$];

  function automatic logic [3:0] pressed(input logic [3:0] raw);
    return raw ^ {4{AL}};
  endfunction

  task automatic model_reset();
    m_sw    = '0;
    m_deb   = '0;
    m_pend  = '0;
    m_en    = '0;
    m_state = 0;
    m_rdata = '0;
    h_sw.delete();
    h_btn.delete();
    u_btn.delete();
    repeat (2) begin
      h_sw.push_back(32'h0);
      h_btn.push_back(pressed(4'h0));
    end
  endtask

  task automatic model_edge();
    logic [31:0] used_sw;
    logic [3:0]  used_b;
    logic [3:0]  press;
    logic [4:0]  nxt;
    logic [1:0]  sel;
    bit          stable;
    sel     = bus.i_lsu_addr[3:2];
    used_sw = h_sw[h_sw.size()-2];
    used_b  = h_btn[h_btn.size()-2];
    u_btn.push_back(used_b);
    if (bus.i_lsu_rden) begin
      case (sel)
        2'd0:    m_rdata = m_sw;
        2'd1:    m_rdata = {28'h0, m_deb};
        2'd2:    m_rdata = {27'h0, m_pend};
        default: m_rdata = {27'h0, m_en};
      endcase
    end
    press = '0;
    for (int i = 0; i < 4; i++) begin
      if (u_btn.size() >= D) begin
        stable = 1'b1;
        for (int j = 1; j <= D; j++) begin
          if (u_btn[u_btn.size()-j][i] == m_deb[i]) stable = 1'b0;
        end
        if (stable) begin
          m_deb[i] = ~m_deb[i];
          press[i] = m_deb[i];
        end
      end
    end
    nxt = m_pend;
    if (bus.i_lsu_wren && sel == 2'd2) nxt = nxt & ~bus.i_lsu_wdata[4:0];
    nxt = nxt | {used_sw != m_sw, press};
    case (m_state)
      0:       if ((m_pend & m_en) != 0) m_state = 1;
      1:       if (ack) m_state = 2;
      default: if (bus.i_lsu_wren && sel == 2'd2) m_state = 0;
    endcase
    m_pend = nxt;
    m_sw   = used_sw;
    if (bus.i_lsu_wren && sel == 2'd3) m_en = bus.i_lsu_wdata[4:0];
    h_sw.push_back(sw);
    h_btn.push_back(pressed(btn));
    if (h_sw.size() > 64) void'(h_sw.pop_front());
    if (h_btn.size() > 64) void'(h_btn.pop_front());
    if (u_btn.size() > 64) void'(u_btn.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check("irq", {31'h0, irq}, {31'h0, m_state == 1});
    check("rdata", bus.o_lsu_rdata, m_rdata);
    bus.i_lsu_wren = 1'b0;
    bus.i_lsu_rden = 1'b0;
    ack            = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] addr, input logic [31:0] data);
    bus.i_lsu_addr  = addr;
    bus.i_lsu_wdata = data;
    bus.i_lsu_wren  = 1'b1;
    step();
  endtask

  task automatic bus_rd(input logic [3:0] addr, output logic [31:0] data);
    bus.i_lsu_addr = addr;
    bus.i_lsu_rden = 1'b1;
    step();
    data = bus.o_lsu_rdata;
  endtask

  initial begin
    logic [31:0] d;
    int unsigned bi;
    int unsigned r;
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    sw              = 32'd100;
    btn             = 4'hF;
    ack             = 1'b0;
    bus.i_lsu_addr  = '0;
    bus.i_lsu_wren  = 1'b0;
    bus.i_lsu_rden  = 1'b0;
    bus.i_lsu_wdata = '0;
    model_reset();
    repeat (3) step();
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", bus.o_lsu_rdata, 32'h0);
    #2 rst_n = 1'b1;
    repeat (4) step();

    // Switch value present at reset release
    bus_rd(4'h0, d);
    check("sw_after_reset", d, 32'd100);
    bus_rd(4'h8, d);
    check("pend_after_reset", d, 32'h10);
    bus_wr(4'hC, 32'h10);
    step();
    check("irq_rise", {31'h0, irq}, 32'h1);

    // Ack, event during service, end of interrupt
    ack = 1'b1;
    step();
    check("irq_ack_drop", {31'h0, irq}, 32'h0);
    sw = 32'd200;
    repeat (4) step();
    check("irq_svc_quiet", {31'h0, irq}, 32'h0);
    bus_rd(4'h8, d);
    check("pend_in_svc", d, 32'h10);
    bus_wr(4'h8, 32'h10);
    repeat (3) step();
    check("irq_after_eoi", {31'h0, irq}, 32'h0);

    // Clean press of button 0, then release
    btn = 4'hE;
    repeat (10) step();
    bus_rd(4'h4, d);
    check("btn_pressed", d, 32'h1);
    bus_rd(4'h8, d);
    check("pend_btn0", d, 32'h1);
    btn = 4'hF;
    repeat (8) step();
    bus_rd(4'h4, d);
    check("btn_released", d, 32'h0);
    bus_wr(4'h8, 32'h1F);
    bus_rd(4'h8, d);
    check("pend_cleared", d, 32'h0);

    // Three-cycle glitch is rejected
    btn = 4'hE;
    repeat (3) step();
    btn = 4'hF;
    repeat (8) step();
    bus_rd(4'h4, d);
    check("glitch_btn", d, 32'h0);
    bus_rd(4'h8, d);
    check("glitch_pend", d, 32'h0);

    // Clear of bit 0 on the same edge a press sets it
    btn = 4'hE;
    repeat (5) step();
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h8, d);
    check("set_beats_clear", d, 32'h1);

    // EOI that leaves an enabled bit pending re-requests
    bus_wr(4'hC, 32'h11);
    step();
    check("irq_btn", {31'h0, irq}, 32'h1);
    ack = 1'b1;
    step();
    bus_wr(4'h8, 32'h08);
    step();
    check("irq_reenter", {31'h0, irq}, 32'h1);

    // Asynchronous reset while requesting
    #2 rst_n = 1'b0;
    #1;
    check("irq_async_rst", {31'h0, irq}, 32'h0);
    check("rdata_async_rst", bus.o_lsu_rdata, 32'h0);
    model_reset();
    sw  = 32'h0;
    btn = 4'hF;
    repeat (2) step();
    #2 rst_n = 1'b1;
    bus_rd(4'h0, d);
    check("rst_sw", d, 32'h0);
    bus_rd(4'h4, d);
    check("rst_btn", d, 32'h0);
    bus_rd(4'h8, d);
    check("rst_pend", d, 32'h0);
    bus_rd(4'hC, d);
    check("rst_en", d, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) sw = sw ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        bi      = $urandom_range(0, 3);
        btn[bi] = ~btn[bi];
      end
      r = $urandom_range(0, 9);
      if (r < 3) begin
        bus.i_lsu_addr = 4'($urandom);
        bus.i_lsu_rden = 1'b1;
      end
      if (r == 3 || r == 4) begin
        bus.i_lsu_addr  = 4'($urandom);
        bus.i_lsu_wdata = $urandom;
        bus.i_lsu_wren  = 1'b1;
      end
      if ((irq && $urandom_range(0, 3) == 0) || $urandom_range(0, 31) == 0) ack = 1'b1;
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_async_rst", {31'h0, irq}, 32'h0);
        model_reset();
        step();
        #2 rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
